// File: rtl/clip_sequencer.sv
// -----------------------------------------------------------------------------
// clip_sequencer
//
// Plays audio clips out of a synchronous sample ROM. A runtime table holds
// NUM_CLIPS inclusive (start, end) address ranges. A play request selects a
// clip and a loop flag. The ROM address steps once every DIV clocks, and a
// step can be held off by output back-pressure (out_ready low).
//
// Ports
//   CLOCK_50      system clock
//   reset         asynchronous, active-high reset
//   clip_start    flattened start addresses, entry i at [i*ADDR_W +: ADDR_W]
//   clip_end      flattened inclusive end addresses, same packing
//   play_req      one-cycle play request (with play_id / play_loop)
//   play_id       clip to play
//   play_loop     loop the clip until stopped or replaced
//   stop          abort playback
//   out_ready     consumer can take a sample
//   rom_q         ROM data, one-cycle read latency from rom_addr
//   rom_addr      ROM address
//   sample_out    current sample (zero while idle)
//   audio_word    sample_out left-justified in 32 bits
//   sample_valid  one-cycle pulse per emitted sample
//   busy          high while playing
//   cur_id        id of the clip most recently started
//   done          one-cycle pulse when a non-looping clip completes
//   bad_req       one-cycle pulse when a request is rejected
//
// Optional build macro CLIP_QUEUE_EN
//   Defined: a valid request during playback goes into a one-deep pending
//   slot and starts when the current clip completes.
//   Undefined (default): a valid request during playback preempts at once.
// -----------------------------------------------------------------------------
module clip_sequencer #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned SAMPLE_W  = 6,
    parameter int unsigned NUM_CLIPS = 4,
    parameter int unsigned ID_W      = 2,
    parameter int unsigned DIV       = 1200
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic [NUM_CLIPS*ADDR_W-1:0] clip_start,
    input  logic [NUM_CLIPS*ADDR_W-1:0] clip_end,
    input  logic                        play_req,
    input  logic [ID_W-1:0]             play_id,
    input  logic                        play_loop,
    input  logic                        stop,
    input  logic                        out_ready,
    input  logic [SAMPLE_W-1:0]         rom_q,
    output logic [ADDR_W-1:0]           rom_addr,
    output logic [SAMPLE_W-1:0]         sample_out,
    output logic [31:0]                 audio_word,
    output logic                        sample_valid,
    output logic                        busy,
    output logic [ID_W-1:0]             cur_id,
    output logic                        done,
    output logic                        bad_req
);

    localparam int unsigned DivW = $clog2(DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

    typedef enum logic {
        StIdle,
        StPlay
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                done_q, done_d;
    logic                bad_q, bad_d;
    logic [DivW-1:0]     div_q, div_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic                loop_q, loop_d;

`ifdef CLIP_QUEUE_EN
    logic                pend_valid_q, pend_valid_d;
    logic [ID_W-1:0]     pend_id_q, pend_id_d;
    logic                pend_loop_q, pend_loop_d;
    logic [ADDR_W-1:0]   pend_start_q, pend_start_d;
    logic [ADDR_W-1:0]   pend_end_q, pend_end_d;
`endif

    // Table lookup for the requested clip; out-of-range ids select nothing.
    logic [ADDR_W-1:0] req_start, req_end;
    logic              id_ok;

    always_comb begin
        req_start = '0;
        req_end   = '0;
        id_ok     = 1'b0;
        for (int i = 0; i < int'(NUM_CLIPS); i++) begin
            if (play_id == ID_W'(i)) begin
                req_start = clip_start[i*ADDR_W +: ADDR_W];
                req_end   = clip_end[i*ADDR_W +: ADDR_W];
                id_ok     = 1'b1;
            end
        end
    end

    logic req_fire, req_ok, req_bad;
    logic tick, at_end;

    assign req_fire = play_req & ~stop;
    assign req_ok   = req_fire & id_ok & (req_start <= req_end);
    assign req_bad  = req_fire & ~(id_ok & (req_start <= req_end));
    assign tick     = (state_q == StPlay) && (div_q == DivLast) && out_ready;
    assign at_end   = (addr_q == end_q);

    // Clip (re)load source, applied after the state decode.
    logic              load_en;
    logic [ADDR_W-1:0] load_start, load_end;
    logic              load_loop;
    logic [ID_W-1:0]   load_id;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;
        id_d       = id_q;
        done_d     = 1'b0;
        bad_d      = req_bad;
        div_d      = div_q;
        start_d    = start_q;
        end_d      = end_q;
        loop_d     = loop_q;
        load_en    = 1'b0;
        load_start = req_start;
        load_end   = req_end;
        load_loop  = play_loop;
        load_id    = play_id;
`ifdef CLIP_QUEUE_EN
        pend_valid_d = pend_valid_q;
        pend_id_d    = pend_id_q;
        pend_loop_d  = pend_loop_q;
        pend_start_d = pend_start_q;
        pend_end_d   = pend_end_q;
`endif

        unique case (state_q)
            StIdle: begin
                sample_d = '0;
                load_en  = req_ok;
            end

            StPlay: begin
                if (stop) begin
                    // Abort: no sample, no done, output silenced.
                    state_d  = StIdle;
                    sample_d = '0;
                    div_d    = '0;
`ifdef CLIP_QUEUE_EN
                    pend_valid_d = 1'b0;
`endif
                end else begin
                    // Divider saturates at DivLast while the consumer stalls.
                    if (div_q != DivLast) begin
                        div_d = div_q + 1'b1;
                    end
                    if (tick) begin
                        sample_d = rom_q;
                        valid_d  = 1'b1;
                        div_d    = '0;
                    end
`ifdef CLIP_QUEUE_EN
                    if (req_ok) begin
                        pend_valid_d = 1'b1;
                        pend_id_d    = play_id;
                        pend_loop_d  = play_loop;
                        pend_start_d = req_start;
                        pend_end_d   = req_end;
                    end
                    if (tick) begin
                        if (!at_end) begin
                            addr_d = addr_q + 1'b1;
                        end else if (loop_q) begin
                            addr_d = start_q;
                        end else begin
                            done_d = 1'b1;
                            // A request arriving on the completing edge is the
                            // newest one, so it beats the slot contents.
                            if (req_ok) begin
                                load_en      = 1'b1;
                                pend_valid_d = 1'b0;
                            end else if (pend_valid_q) begin
                                load_en      = 1'b1;
                                load_start   = pend_start_q;
                                load_end     = pend_end_q;
                                load_loop    = pend_loop_q;
                                load_id      = pend_id_q;
                                pend_valid_d = 1'b0;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end
`else
                    if (req_ok) begin
                        // Preempt; the same-edge tick sample above still goes out.
                        load_en = 1'b1;
                    end else if (tick) begin
                        if (!at_end) begin
                            addr_d = addr_q + 1'b1;
                        end else if (loop_q) begin
                            addr_d = start_q;
                        end else begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
`endif
                end
            end

            default: state_d = StIdle;
        endcase

        if (load_en) begin
            state_d = StPlay;
            addr_d  = load_start;
            div_d   = '0;
            start_d = load_start;
            end_d   = load_end;
            loop_d  = load_loop;
            id_d    = load_id;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            id_q     <= '0;
            done_q   <= 1'b0;
            bad_q    <= 1'b0;
            div_q    <= '0;
            start_q  <= '0;
            end_q    <= '0;
            loop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            id_q     <= id_d;
            done_q   <= done_d;
            bad_q    <= bad_d;
            div_q    <= div_d;
            start_q  <= start_d;
            end_q    <= end_d;
            loop_q   <= loop_d;
        end
    end

`ifdef CLIP_QUEUE_EN
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_id_q    <= '0;
            pend_loop_q  <= 1'b0;
            pend_start_q <= '0;
            pend_end_q   <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_id_q    <= pend_id_d;
            pend_loop_q  <= pend_loop_d;
            pend_start_q <= pend_start_d;
            pend_end_q   <= pend_end_d;
        end
    end
`endif

    assign rom_addr     = addr_q;
    assign sample_out   = sample_q;
    assign audio_word   = {sample_q, {(32 - SAMPLE_W){1'b0}}};
    assign sample_valid = valid_q;
    assign busy         = (state_q == StPlay);
    assign cur_id       = id_q;
    assign done         = done_q;
    assign bad_req      = bad_q;

endmodule

// File: tb/tb_clip_sequencer.sv
// Bench for clip_sequencer: DIV=4, clip0=[10,13], clip1=[20,20], clip2=[5,3],
// three clips so id 3 is out of range. A registered ROM model returns
// addr[5:0] ^ 6'h2A; the expected samples in the vectors are worked by hand.
module tb_clip_sequencer;

    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned SAMPLE_W  = 6;
    localparam int unsigned NUM_CLIPS = 3;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned DIV       = 4;

    logic                        clk;
    logic                        rst;
    logic [NUM_CLIPS*ADDR_W-1:0] clip_start;
    logic [NUM_CLIPS*ADDR_W-1:0] clip_end;
    logic                        play_req;
    logic [ID_W-1:0]             play_id;
    logic                        play_loop;
    logic                        stop;
    logic                        out_ready;
    logic [SAMPLE_W-1:0]         rom_q;
    logic [ADDR_W-1:0]           rom_addr;
    logic [SAMPLE_W-1:0]         sample_out;
    logic [31:0]                 audio_word;
    logic                        sample_valid;
    logic                        busy;
    logic [ID_W-1:0]             cur_id;
    logic                        done;
    logic                        bad_req;

    int n_checks = 0;
    int n_fail   = 0;

    clip_sequencer #(
        .ADDR_W    (ADDR_W),
        .SAMPLE_W  (SAMPLE_W),
        .NUM_CLIPS (NUM_CLIPS),
        .ID_W      (ID_W),
        .DIV       (DIV)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (rst),
        .clip_start   (clip_start),
        .clip_end     (clip_end),
        .play_req     (play_req),
        .play_id      (play_id),
        .play_loop    (play_loop),
        .stop         (stop),
        .out_ready    (out_ready),
        .rom_q        (rom_q),
        .rom_addr     (rom_addr),
        .sample_out   (sample_out),
        .audio_word   (audio_word),
        .sample_valid (sample_valid),
        .busy         (busy),
        .cur_id       (cur_id),
        .done         (done),
        .bad_req      (bad_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM model, one cycle of read latency.
    always @(posedge clk) rom_q <= rom_addr[5:0] ^ 6'h2A;

    typedef struct {
        logic            req;
        logic [1:0]      id;
        logic            loop;
        logic            stp;
        logic            rdy;
        logic [17:0]     addr;
        logic            valid;
        logic            busy;
        logic            done;
        logic            bad;
        logic [5:0]      smp;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int req, input int id, input int lp, input int stp,
                           input int rdy, input int addr, input int valid, input int bsy,
                           input int dn, input int bad, input int smp);
        vec_t v;
        v.req   = req[0];
        v.id    = id[1:0];
        v.loop  = lp[0];
        v.stp   = stp[0];
        v.rdy   = rdy[0];
        v.addr  = addr[17:0];
        v.valid = valid[0];
        v.busy  = bsy[0];
        v.done  = dn[0];
        v.bad   = bad[0];
        v.smp   = smp[5:0];
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int req, input int id, input int lp, input int stp,
                         input int rdy);
        play_req  = req[0];
        play_id   = id[1:0];
        play_loop = lp[0];
        stop      = stp[0];
        out_ready = rdy[0];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int ndone;

    initial begin
        clip_start = {18'd5, 18'd20, 18'd10};
        clip_end   = {18'd3, 18'd20, 18'd13};
        drive(0, 0, 0, 0, 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset addr", rom_addr, 0);
        chk("reset busy", busy, 0);
        chk("reset valid", sample_valid, 0);
        chk("reset sample", sample_out, 0);
        chk("reset cur_id", cur_id, 0);
        chk("reset done", done, 0);
        chk("reset bad", bad_req, 0);
        rst = 1'b0;

        // Clip0 without loop, then rejected requests and an idle stop.
        add_vec(1, 0, 0, 0, 1, 10, 0, 1, 0, 0, 0);
        repeat (3) add_vec(0, 0, 0, 0, 1, 10, 0, 1, 0, 0, 0);
        add_vec(0, 0, 0, 0, 1, 11, 1, 1, 0, 0, 32);
        repeat (3) add_vec(0, 0, 0, 0, 1, 11, 0, 1, 0, 0, 32);
        add_vec(0, 0, 0, 0, 1, 12, 1, 1, 0, 0, 33);
        repeat (3) add_vec(0, 0, 0, 0, 1, 12, 0, 1, 0, 0, 33);
        add_vec(0, 0, 0, 0, 1, 13, 1, 1, 0, 0, 38);
        repeat (3) add_vec(0, 0, 0, 0, 1, 13, 0, 1, 0, 0, 38);
        add_vec(0, 0, 0, 0, 1, 13, 1, 0, 1, 0, 39);
        add_vec(0, 0, 0, 0, 1, 13, 0, 0, 0, 0, 0);
        add_vec(1, 2, 0, 0, 1, 13, 0, 0, 0, 1, 0);
        add_vec(1, 3, 0, 0, 1, 13, 0, 0, 0, 1, 0);
        add_vec(0, 0, 0, 1, 1, 13, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].req, vecs[i].id, vecs[i].loop, vecs[i].stp, vecs[i].rdy);
            step();
            chk($sformatf("vec%0d addr", i), rom_addr, vecs[i].addr);
            chk($sformatf("vec%0d valid", i), sample_valid, vecs[i].valid);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d done", i), done, vecs[i].done);
            chk($sformatf("vec%0d bad", i), bad_req, vecs[i].bad);
            chk($sformatf("vec%0d sample", i), sample_out, vecs[i].smp);
            chk($sformatf("vec%0d word", i), audio_word, {vecs[i].smp, 26'd0});
        end

        // Looping single-sample clip1, then stop.
        drive(1, 1, 1, 0, 1);
        step();
        chk("loop start addr", rom_addr, 20);
        chk("loop cur_id", cur_id, 1);
        drive(0, 0, 0, 0, 1);
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("loop valid %0d", k), sample_valid, (k % 4 == 0) ? 1 : 0);
            if (done) ndone++;
        end
        chk("loop addr", rom_addr, 20);
        chk("loop sample", sample_out, 62);
        chk("loop busy", busy, 1);
        chk("loop done count", ndone, 0);
        drive(0, 0, 0, 1, 1);
        step();
        chk("stop busy", busy, 0);
        chk("stop sample", sample_out, 0);
        chk("stop done", done, 0);
        chk("stop valid", sample_valid, 0);
        drive(0, 0, 0, 0, 1);

        // Back-pressure stall at the last divider count.
        drive(1, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        repeat (3) step();
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("stall valid %0d", k), sample_valid, 0);
            chk($sformatf("stall addr %0d", k), rom_addr, 10);
        end
        drive(0, 0, 0, 0, 1);
        step();
        chk("unstall valid", sample_valid, 1);
        chk("unstall sample", sample_out, 32);
        chk("unstall addr", rom_addr, 11);
        repeat (3) step();
        chk("post-stall gap", sample_valid, 0);
        step();
        chk("post-stall valid", sample_valid, 1);
        chk("post-stall addr", rom_addr, 12);
        drive(0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 1);

        // Request for clip1 while clip0 is at address 11.
        drive(1, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        repeat (4) step();
        chk("pre addr", rom_addr, 11);
        drive(1, 1, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
`ifdef CLIP_QUEUE_EN
        chk("queue hold addr", rom_addr, 11);
        chk("queue hold id", cur_id, 0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done) ndone++;
        end
        chk("queue early done", ndone, 0);
        step();
        chk("queue done", done, 1);
        chk("queue last valid", sample_valid, 1);
        chk("queue last sample", sample_out, 39);
        chk("queue next addr", rom_addr, 20);
        chk("queue busy", busy, 1);
        chk("queue cur_id", cur_id, 1);
        repeat (4) step();
`else
        chk("preempt addr", rom_addr, 20);
        chk("preempt cur_id", cur_id, 1);
        chk("preempt done", done, 0);
        chk("preempt busy", busy, 1);
        repeat (4) step();
`endif
        chk("clip1 valid", sample_valid, 1);
        chk("clip1 sample", sample_out, 62);
        chk("clip1 done", done, 1);
        chk("clip1 busy", busy, 0);

        // Rejected requests mid-play, then stop beats play_req.
        drive(1, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        step();
        drive(1, 2, 0, 0, 1);
        step();
        chk("bad2 pulse", bad_req, 1);
        chk("bad2 busy", busy, 1);
        chk("bad2 addr", rom_addr, 10);
        drive(1, 3, 0, 0, 1);
        step();
        chk("bad3 pulse", bad_req, 1);
        chk("bad3 busy", busy, 1);
        chk("bad3 addr", rom_addr, 10);
        drive(1, 1, 0, 1, 1);
        step();
        chk("stopwin busy", busy, 0);
        chk("stopwin valid", sample_valid, 0);
        chk("stopwin cur_id", cur_id, 0);
        chk("stopwin bad", bad_req, 0);
        chk("stopwin sample", sample_out, 0);
        drive(0, 0, 0, 0, 1);

        // Asynchronous reset while playing at address 12.
        drive(1, 0, 0, 0, 1);
        step();
        drive(0, 0, 0, 0, 1);
        repeat (8) step();
        chk("prereset addr", rom_addr, 12);
        #2 rst = 1'b1;
        #1;
        chk("async addr", rom_addr, 0);
        chk("async busy", busy, 0);
        chk("async valid", sample_valid, 0);
        chk("async sample", sample_out, 0);
        chk("async word", audio_word, 0);
        chk("async done", done, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) step();
        chk("post-reset busy", busy, 0);
        chk("post-reset addr", rom_addr, 0);
        chk("post-reset valid", sample_valid, 0);
        drive(1, 1, 0, 0, 1);
        step();
        chk("restart busy", busy, 1);
        chk("restart addr", rom_addr, 20);
        chk("restart cur_id", cur_id, 1);
        drive(0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
